alu_flag_unit: RTL and testbench



---
 rtl/alu_flag_unit.sv | 129 ++++++++++++
 tb/tb_alu_flag_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// Registered C/Z/N/V status flags for the ALU, with optional sticky C/V and a
// saturating carry/borrow event counter (enabled by defining ALU_FLAG_STICKY_EN).
module alu_flag_unit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] result,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             cout,
    input  logic             bout,
    input  logic             clr,
    output logic             valid_out,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             sticky_c,
    output logic             sticky_v,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;

    logic w_c;
    logic w_v;
    logic w_z;
    logic w_n;
    logic w_res_msb;

    logic r_valid;
    logic r_c;
    logic r_z;
    logic r_n;
    logic r_v;

    assign w_res_msb = result[WIDTH-1];

    // Next-flag values; only add/sub can raise carry or overflow.
    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        w_z = (result == '0);
        w_n = w_res_msb;
        case (sel)
            SEL_ADD: begin
                w_c = cout;
                w_v = (a_msb == b_msb) && (w_res_msb != a_msb);
            end
            SEL_SUB: begin
                w_c = bout;
                w_v = (a_msb != b_msb) && (w_res_msb != a_msb);
            end
            default: begin
                w_c = 1'b0;
                w_v = 1'b0;
            end
        endcase
    end

    // Flag register: loads on a valid op, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_c <= w_c;
                r_z <= w_z;
                r_n <= w_n;
                r_v <= w_v;
            end
        end
    end

    assign valid_out = r_valid;
    assign flag_c    = r_c;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_v    = r_v;

`ifdef ALU_FLAG_STICKY_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_sticky_c;
    logic             r_sticky_v;
    logic [CNT_W-1:0] r_evt_cnt;

    // clr wins over a same-cycle valid op; that op is not accumulated.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky_c <= 1'b0;
            r_sticky_v <= 1'b0;
            r_evt_cnt  <= '0;
        end else if (clr) begin
            r_sticky_c <= 1'b0;
            r_sticky_v <= 1'b0;
            r_evt_cnt  <= '0;
        end else if (valid_in) begin
            r_sticky_c <= r_sticky_c | w_c;
            r_sticky_v <= r_sticky_v | w_v;
            if (w_c && (r_evt_cnt != CNT_MAX)) begin
                r_evt_cnt <= r_evt_cnt + CNT_W'(1);
            end
        end
    end

    assign sticky_c = r_sticky_c;
    assign sticky_v = r_sticky_v;
    assign evt_cnt  = r_evt_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr;
    assign sticky_c     = 1'b0;
    assign sticky_v     = 1'b0;
    assign evt_cnt      = '0;
`endif

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed scenarios plus randomized
// traffic compared every cycle against a spec-level model.
module tb_alu_flag_unit;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int          CNT_MX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             valid_in;
    logic [2:0]       sel;
    logic [WIDTH-1:0] result;
    logic             a_msb;
    logic             b_msb;
    logic             cout;
    logic             bout;
    logic             clr;
    logic             valid_out;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic             sticky_c;
    logic             sticky_v;
    logic [CNT_W-1:0] evt_cnt;

    alu_flag_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .sel(sel),
        .result(result), .a_msb(a_msb), .b_msb(b_msb), .cout(cout),
        .bout(bout), .clr(clr), .valid_out(valid_out), .flag_c(flag_c),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .sticky_c(sticky_c), .sticky_v(sticky_v), .evt_cnt(evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

`ifdef ALU_FLAG_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    // model state
    int m_vo, m_c, m_z, m_n, m_v, m_sc, m_sv, m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, from the sampled inputs.
    task automatic model_edge();
        int c, v, sgn_r, sgn_a, sgn_b;
        sgn_r = int'(result[WIDTH-1]);
        sgn_a = int'(a_msb);
        sgn_b = int'(b_msb);
        c = 0;
        v = 0;
        if (sel == 3'd0) begin
            c = int'(cout);
            v = (sgn_a == sgn_b && sgn_r != sgn_a) ? 1 : 0;
        end else if (sel == 3'd1) begin
            c = int'(bout);
            v = (sgn_a != sgn_b && sgn_r != sgn_a) ? 1 : 0;
        end
        if (reset) begin
            m_vo = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
            m_sc = 0; m_sv = 0; m_cnt = 0;
        end else begin
            m_vo = int'(valid_in);
            if (valid_in) begin
                m_c = c;
                m_v = v;
                m_z = (int'(result) == 0) ? 1 : 0;
                m_n = sgn_r;
            end
            if (STICKY) begin
                if (clr) begin
                    m_sc = 0; m_sv = 0; m_cnt = 0;
                end else if (valid_in) begin
                    m_sc = m_sc | c;
                    m_sv = m_sv | v;
                    if (c == 1 && m_cnt < CNT_MX) m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_out", int'(valid_out), m_vo);
            chk("flag_c",    int'(flag_c),    m_c);
            chk("flag_z",    int'(flag_z),    m_z);
            chk("flag_n",    int'(flag_n),    m_n);
            chk("flag_v",    int'(flag_v),    m_v);
            chk("sticky_c",  int'(sticky_c),  m_sc);
            chk("sticky_v",  int'(sticky_v),  m_sv);
            chk("evt_cnt",   int'(evt_cnt),   m_cnt);
        end
    end

    // Apply inputs, clock one edge, update model, land on the next negedge.
    task automatic step(input bit rs, input bit v, input logic [2:0] s,
                        input logic [WIDTH-1:0] r, input bit am, input bit bm,
                        input bit co, input bit bo, input bit cl);
        reset = rs; valid_in = v; sel = s; result = r;
        a_msb = am; b_msb = bm; cout = co; bout = bo; clr = cl;
        @(posedge clk);
        model_edge();
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; sel = '0; result = '0;
        a_msb = 1'b0; b_msb = 1'b0; cout = 1'b0; bout = 1'b0; clr = 1'b0;
        @(negedge clk);

        // Reset held with valid traffic and random inputs.
        for (int i = 0; i < 2; i++)
            step(1, 1, 3'($urandom), WIDTH'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk("rst_all", {valid_out, flag_c, flag_z, flag_n, flag_v,
                        sticky_c, sticky_v, evt_cnt}, 0);

        // Add overflow: 0+0 sign giving negative result.
        step(0, 1, 3'b000, 4'b1000, 0, 0, 0, 0, 0);
        chk("add_ovf_cznv", {valid_out, flag_c, flag_z, flag_n, flag_v}, 5'b10011);

        // Subtract with borrow, zero result.
        step(0, 1, 3'b001, 4'b0000, 0, 0, 0, 1, 0);
        chk("sub_brw_cznv", {flag_c, flag_z, flag_n, flag_v}, 4'b1100);

        // Logic op ignores cout/bout.
        step(0, 1, 3'b010, 4'b0110, 1, 0, 1, 1, 0);
        chk("and_no_cv", {flag_c, flag_v}, 0);

        // Hold: one valid op then three idle cycles.
        step(0, 1, 3'b001, 4'b1010, 0, 1, 0, 1, 0);
        chk("hold_v0", int'(valid_out), 1);
        chk("hold_f0", {flag_c, flag_z, flag_n, flag_v}, 4'b1011);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 3'($urandom), WIDTH'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 0);
            chk("hold_vo", int'(valid_out), 0);
            chk("hold_f",  {flag_c, flag_z, flag_n, flag_v}, 4'b1011);
        end

        // Saturation: clear, then five carrying adds.
        step(0, 0, 3'b000, 4'b0000, 0, 0, 0, 0, 1);
        chk("clr_cnt", int'(evt_cnt), 0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 3'b000, 4'b0001, 1, 0, 1, 0, 0);
            chk("sat_cnt", int'(evt_cnt), STICKY ? ((i < 3) ? i : 3) : 0);
            chk("sat_sc",  int'(sticky_c), STICKY ? 1 : 0);
            chk("sat_fc",  int'(flag_c), 1);
        end
        step(0, 1, 3'b000, 4'b0001, 1, 0, 1, 0, 1);
        chk("clr_pri", {int'(evt_cnt), int'(sticky_c), int'(flag_c)}, 1);
        step(0, 1, 3'b011, 4'b0001, 0, 0, 1, 1, 0);
        chk("fc_toggle", int'(flag_c), 0);

        // Randomized traffic with occasional clr and mid-stream reset.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                 3'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));

        // Reset with a pending op and clr discards everything.
        step(1, 1, 3'b000, 4'b1000, 0, 0, 1, 1, 1);
        chk("rst_mid", {valid_out, flag_c, flag_n, flag_v, sticky_c, evt_cnt}, 0);
        step(0, 1, 3'b100, 4'b0000, 0, 0, 0, 0, 0);
        chk("post_rst", {valid_out, flag_z}, 2'b11);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
